branch_seq: RTL and testbench

- Consumes the active-low flag outputs of the processor-status unit (n_NOUT, n_VOUT, n_COUT, n_ZOUT) and sequences conditional relative branches.
- Captures a branch opcode and its PC, then samples the offset operand and the flags.
- Decides taken / not-taken and computes the target, including the page-crossing fix-up.
- Issues a one-cycle PC load, with 6502 cycle timing of 2 / 3 / 4 cycles.

---
 rtl/branch_seq.sv | 103 ++++++++++
 tb/tb_branch_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/branch_seq.sv
// branch_seq: 6502-style conditional relative branch sequencer (2/3/4 cycle timing)
// consumes active-low N/V/C/Z flags and emits a one-cycle PC load with page fix-up
module branch_seq #(
    parameter bit CHECK_OP = 1'b1
) (
    input  logic        PHI0,
    input  logic        RES,
    input  logic        BR_START,
    input  logic [7:0]  IR,
    input  logic [15:0] PC_IN,
    input  logic [7:0]  DB,
    input  logic        n_NOUT,
    input  logic        n_VOUT,
    input  logic        n_COUT,
    input  logic        n_ZOUT,
    output logic [15:0] PC_OUT,
    output logic        PC_LOAD,
    output logic        TAKEN,
    output logic        PAGE_X,
    output logic        BUSY
);
    typedef enum logic [1:0] {IDLE, OPER, ADDL, ADDH} state_t;
    state_t state, nxt;
    logic [1:0] sel;
    logic cmp;
    logic [15:0] npc;
    logic [7:0] off, lo;
    logic [3:0] flags;
    logic flag, start;
    logic [8:0] sum;
    logic [15:0] pc_n;
    logic ld_n, taken_n, px_n;
    assign flags = {n_NOUT, n_VOUT, n_COUT, n_ZOUT};
    assign flag = ~flags[2'd3 - sel];
    assign start = BR_START && (!CHECK_OP || IR[4:0] == 5'b10000);
    assign sum = {1'b0, npc[7:0]} + {1'b0, off};
    always_comb begin
        nxt = state;
        pc_n = PC_OUT;
        ld_n = 1'b0;
        taken_n = TAKEN;
        px_n = PAGE_X;
        case (state)
            IDLE: nxt = start ? OPER : IDLE;
            OPER: begin
                if (flag != cmp) begin
                    pc_n = npc;
                    ld_n = 1'b1;
                    taken_n = 1'b0;
                    px_n = 1'b0;
                    nxt = IDLE;
                end else nxt = ADDL;
            end
            // a carry that disagrees with the offset sign means the high byte must move
            ADDL: begin
                if (off[7] == sum[8]) begin
                    pc_n = {npc[15:8], sum[7:0]};
                    ld_n = 1'b1;
                    taken_n = 1'b1;
                    px_n = 1'b0;
                    nxt = IDLE;
                end else nxt = ADDH;
            end
            ADDH: begin
                pc_n = {off[7] ? npc[15:8] - 8'd1 : npc[15:8] + 8'd1, lo};
                ld_n = 1'b1;
                taken_n = 1'b1;
                px_n = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge PHI0 or posedge RES) begin
        if (RES) begin
            state <= IDLE;
            PC_OUT <= 16'h0000;
            PC_LOAD <= 1'b0;
            TAKEN <= 1'b0;
            PAGE_X <= 1'b0;
            BUSY <= 1'b0;
            sel <= 2'd0;
            cmp <= 1'b0;
            npc <= 16'h0000;
            off <= 8'h00;
            lo <= 8'h00;
        end else begin
            state <= nxt;
            PC_OUT <= pc_n;
            PC_LOAD <= ld_n;
            TAKEN <= taken_n;
            PAGE_X <= px_n;
            BUSY <= nxt != IDLE;
            if (state == IDLE && start) begin
                sel <= IR[7:6];
                cmp <= IR[5];
                npc <= PC_IN + 16'd2;
            end
            if (state == OPER) off <= DB;
            if (state == ADDL) lo <= sum[7:0];
        end
    end
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: table vectors, corner sequences and random branches vs. a target-address model
module tb_branch_seq;
    logic PHI0 = 1'b0, RES = 1'b1, BR_START = 1'b0;
    logic [7:0] IR = 8'h00, DB = 8'h00;
    logic [15:0] PC_IN = 16'h0000;
    logic n_NOUT = 1'b1, n_VOUT = 1'b1, n_COUT = 1'b1, n_ZOUT = 1'b1;
    logic [15:0] PC_OUT;
    logic PC_LOAD, TAKEN, PAGE_X, BUSY;
    int n_chk = 0, n_fail = 0;

    branch_seq #(.CHECK_OP(1'b1)) dut (
        .PHI0(PHI0), .RES(RES), .BR_START(BR_START), .IR(IR), .PC_IN(PC_IN), .DB(DB),
        .n_NOUT(n_NOUT), .n_VOUT(n_VOUT), .n_COUT(n_COUT), .n_ZOUT(n_ZOUT),
        .PC_OUT(PC_OUT), .PC_LOAD(PC_LOAD), .TAKEN(TAKEN), .PAGE_X(PAGE_X), .BUSY(BUSY)
    );

    always #5 PHI0 = ~PHI0;

    typedef struct {
        logic [7:0] ir;
        logic [15:0] pc;
        logic [7:0] db;
        logic [3:0] f;
        logic [15:0] pc_e;
        logic t_e;
        logic p_e;
        int cyc_e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // f holds the true (active-high) flags as {N,V,C,Z}; caller sits just after a falling edge
    task automatic do_branch(input logic [7:0] ir, input logic [15:0] pc, input logic [7:0] db,
                             input logic [3:0] f, input logic [15:0] pc_e, input logic t_e,
                             input logic p_e, input int cyc_e, input bit chain);
        int n;
        bit got;
        BR_START = 1'b1; IR = ir; PC_IN = pc;
        @(negedge PHI0);
        BR_START = 1'b0; DB = db;
        {n_NOUT, n_VOUT, n_COUT, n_ZOUT} = ~f;
        chk("busy_after_start", BUSY, 1);
        n = 0; got = 0;
        while (!got && n < 6) begin
            @(negedge PHI0);
            n++;
            DB = 8'($urandom);
            {n_NOUT, n_VOUT, n_COUT, n_ZOUT} = 4'($urandom);
            if (PC_LOAD) got = 1;
        end
        chk("load_latency", got ? n : 99, cyc_e);
        chk("pc_out", PC_OUT, pc_e);
        chk("taken", TAKEN, t_e);
        chk("page_x", PAGE_X, p_e);
        chk("busy_in_load", BUSY, 0);
        if (!chain) begin
            @(negedge PHI0);
            chk("load_one_cycle", PC_LOAD, 0);
        end
    endtask

    vec_t tbl[7];
    logic [15:0] npc, tgt;
    logic flag, t, p;
    logic [7:0] ir, db;
    logic [15:0] pc;
    logic [3:0] f;
    logic [15:0] held;

    initial begin
        tbl[0] = '{8'hD0, 16'h1000, 8'h05, 4'b0000, 16'h1007, 1'b1, 1'b0, 2};
        tbl[1] = '{8'h70, 16'h2000, 8'h33, 4'b0000, 16'h2002, 1'b0, 1'b0, 1};
        tbl[2] = '{8'h90, 16'h10F0, 8'h20, 4'b0000, 16'h1112, 1'b1, 1'b1, 3};
        tbl[3] = '{8'h30, 16'h1000, 8'hFA, 4'b1000, 16'h0FFC, 1'b1, 1'b1, 3};
        tbl[4] = '{8'hF0, 16'hFFFE, 8'h01, 4'b0001, 16'h0001, 1'b1, 1'b0, 2};
        tbl[5] = '{8'hF0, 16'hFFFE, 8'hFF, 4'b0001, 16'hFFFF, 1'b1, 1'b1, 3};
        tbl[6] = '{8'h10, 16'h3000, 8'h80, 4'b1000, 16'h3002, 1'b0, 1'b0, 1};

        repeat (2) @(negedge PHI0);
        chk("rst_pc_out", PC_OUT, 0);
        chk("rst_pc_load", PC_LOAD, 0);
        chk("rst_taken", TAKEN, 0);
        chk("rst_page_x", PAGE_X, 0);
        chk("rst_busy", BUSY, 0);
        RES = 1'b0;
        @(negedge PHI0);

        foreach (tbl[i])
            do_branch(tbl[i].ir, tbl[i].pc, tbl[i].db, tbl[i].f, tbl[i].pc_e,
                      tbl[i].t_e, tbl[i].p_e, tbl[i].cyc_e, 1'b0);

        // back-to-back: second start lands in the first sequence's PC_LOAD cycle
        do_branch(8'hD0, 16'h1000, 8'h05, 4'b0000, 16'h1007, 1'b1, 1'b0, 2, 1'b1);
        do_branch(8'h90, 16'h10F0, 8'h20, 4'b0000, 16'h1112, 1'b1, 1'b1, 3, 1'b0);

        // non-branch opcode is rejected and outputs hold
        held = PC_OUT;
        BR_START = 1'b1; IR = 8'hA9; PC_IN = 16'h4000;
        @(negedge PHI0);
        BR_START = 1'b0;
        chk("bad_op_busy", BUSY, 0);
        repeat (3) @(negedge PHI0);
        chk("bad_op_load", PC_LOAD, 0);
        chk("bad_op_pc", PC_OUT, held);
        chk("bad_op_page_x", PAGE_X, 1);

        // reset during ADDH aborts the sequence
        BR_START = 1'b1; IR = 8'h90; PC_IN = 16'h10F0;
        @(negedge PHI0);
        BR_START = 1'b0; DB = 8'h20; {n_NOUT, n_VOUT, n_COUT, n_ZOUT} = 4'b1111;
        repeat (2) @(negedge PHI0);
        chk("pre_rst_busy", BUSY, 1);
        RES = 1'b1;
        #2;
        chk("abort_pc_out", PC_OUT, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_taken", TAKEN, 0);
        chk("abort_page_x", PAGE_X, 0);
        RES = 1'b0;
        repeat (4) begin
            @(negedge PHI0);
            chk("abort_no_load", PC_LOAD, 0);
        end

        // random valid branches against an address-arithmetic model
        for (int k = 0; k < 40; k++) begin
            ir = {2'($urandom), 1'($urandom), 5'b10000};
            pc = 16'($urandom);
            db = 8'($urandom);
            f = 4'($urandom);
            npc = pc + 16'd2;
            flag = f[3 - ir[7:6]];
            t = (flag == ir[5]);
            tgt = npc + {{8{db[7]}}, db};
            p = t && (tgt[15:8] != npc[15:8]);
            do_branch(ir, pc, db, f, t ? tgt : npc, t, p, !t ? 1 : (p ? 3 : 2), 1'($urandom));
        end
        @(negedge PHI0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
